// File: rtl/buf_delay_checker.sv
// Buffer delay checker: drives a 0->1->0 stimulus into a buffer under test and
// measures the rise and fall delays of its output in clock cycles.
module buf_delay_checker #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int MAX_DLY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y_in,
    output logic             a_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout_err,
    output logic [CNT_W-1:0] rise_dly,
    output logic [CNT_W-1:0] fall_dly
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_RISE   = 3'd2;
    localparam logic [2:0] S_FALL   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_DLY);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic [CNT_W-1:0] fall_q, fall_d;
    logic             a_out_q, busy_q, done_q;
    logic             at_limit;

    assign at_limit = (cnt_q == TIMEOUT_C);

    always_comb begin
        // NOTE: every signal gets a default here so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        rise_d  = rise_q;
        fall_d  = fall_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                    rise_d  = '0;
                    fall_d  = '0;
                end
            end
            S_SETTLE: begin
                if (!y_in) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end else if (at_limit) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RISE: begin
                // A match wins over a simultaneous timeout.
                if (y_in) begin
                    state_d = S_FALL;
                    rise_d  = cnt_q;
                    cnt_d   = '0;
                end else if (at_limit) begin
                    state_d = S_DONE;
                    rise_d  = TIMEOUT_C;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FALL: begin
                if (!y_in) begin
                    state_d = S_DONE;
                    fall_d  = cnt_q;
                end else if (at_limit) begin
                    state_d = S_DONE;
                    fall_d  = TIMEOUT_C;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Verdict is formed on entry to DONE so it is valid alongside the done pulse.
        if (state_d == S_DONE) begin
            pass_d = !tmo_d && (rise_d <= MAX_C) && (fall_d <= MAX_C);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            rise_q  <= '0;
            fall_q  <= '0;
            a_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            // Flag outputs decode the next state so they change together with it.
            a_out_q <= (state_d == S_RISE);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign a_out       = a_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout_err = tmo_q;
    assign rise_dly    = rise_q;
    assign fall_dly    = fall_q;

endmodule

// File: tb/tb_buf_delay_checker.sv
// Self-checking bench for buf_delay_checker: a configurable delay-line or
// stuck-at buffer model drives y_in, and each run is compared to a reference.
module tb_buf_delay_checker;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 15;
    localparam int MAX_DLY = 3;

    localparam int M_DELAY  = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             y_in;
    logic             a_out, busy, done, pass, timeout_err;
    logic [CNT_W-1:0] rise_dly, fall_dly;

    int          mode = M_DELAY;
    int          dly  = 0;
    logic [31:0] hist = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    buf_delay_checker #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MAX_DLY(MAX_DLY)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .y_in       (y_in),
        .a_out      (a_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout_err(timeout_err),
        .rise_dly   (rise_dly),
        .fall_dly   (fall_dly)
    );

    always #5 clk = ~clk;

    // Buffer under test: hist[i] holds a_out from i+1 cycles ago.
    always @(posedge clk) hist <= {hist[30:0], a_out};

    always_comb begin
        y_in = 1'b0;
        if (mode == M_STUCK1)      y_in = 1'b1;
        else if (mode == M_STUCK0) y_in = 1'b0;
        else if (dly == 0)         y_in = a_out;
        else                       y_in = hist[dly-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outcome of one run; lat is cycles from the start-sampling edge to done.
    task automatic ref_model(input int m, input int d, output int lat, output int highs,
                             output int r, output int f, output int e, output int p);
        if (m == M_STUCK1) begin
            lat = TIMEOUT + 2; highs = 0; r = 0; f = 0; e = 1;
        end else if (m == M_STUCK0 || d > TIMEOUT) begin
            lat = TIMEOUT + 3; highs = TIMEOUT + 1; r = TIMEOUT; f = 0; e = 1;
        end else begin
            lat = 4 + 2 * d; highs = d + 1; r = d; f = d; e = 0;
        end
        p = (e == 0 && r <= MAX_DLY && f <= MAX_DLY) ? 1 : 0;
    endtask

    task automatic run(input int m, input int d);
        int lat, hi, r, f, e, p;
        int k, highs, extra;
        ref_model(m, d, lat, hi, r, f, e, p);
        @(negedge clk);
        mode  = m;
        dly   = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_clr_rise", rise_dly, 0);
        check("start_clr_fall", fall_dly, 0);
        check("start_clr_pass", pass, 0);
        check("start_clr_tmo", timeout_err, 0);
        highs = 0;
        for (k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (a_out) highs++;
            if (done) break;
        end
        check("done_latency", k, lat);
        check("done_rise", rise_dly, r);
        check("done_fall", fall_dly, f);
        check("done_tmo", timeout_err, e);
        check("done_pass", pass, p);
        check("done_aout", a_out, 0);
        check("aout_high_cycles", highs, hi);
        @(negedge clk);
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        check("hold_rise", rise_dly, r);
        check("hold_pass", pass, p);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || a_out) extra++;
        end
        check("idle_quiet", extra, 0);
        check("idle_hold_tmo", timeout_err, e);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_aout", a_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Directed cases: loopback, flop chains, stuck-at and limit boundaries.
        run(M_DELAY, 0);
        run(M_DELAY, 2);
        run(M_DELAY, 5);
        run(M_STUCK0, 0);
        run(M_DELAY, 3);
        run(M_DELAY, 4);
        run(M_DELAY, 15);
        run(M_DELAY, 16);
        run(M_STUCK1, 0);

        // Reset in the middle of RISE, with start asserted alongside it.
        @(negedge clk);
        mode  = M_DELAY;
        dly   = 5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10 && !a_out; k++) @(negedge clk);
        check("rst_pre_aout", a_out, 1);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("midrst_aout", a_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_pass", pass, 0);
        check("midrst_tmo", timeout_err, 0);
        check("midrst_rise", rise_dly, 0);
        check("midrst_fall", fall_dly, 0);
        @(negedge clk);
        check("midrst_idle", busy, 0);
        repeat (40) @(negedge clk);
        run(M_DELAY, 1);

        // start held high: one run per pass through IDLE.
        @(negedge clk);
        mode  = M_DELAY;
        dly   = 0;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("held_done", done, (k == 4 || k == 9));
            check("held_busy", busy, !(k == 5 || k == 10));
        end
        start = 1'b0;
        check("held_pass", pass, 1);
        @(negedge clk);
        check("held_stop", busy, 0);
        repeat (40) @(negedge clk);

        // Randomized buffer behaviours.
        for (int i = 0; i < 16; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 8)      run(M_STUCK0, 0);
            else if (sel == 9) run(M_STUCK1, 0);
            else               run(M_DELAY, $urandom_range(0, 20));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
